// File: rtl/counter_arbiter_pkg.sv
// Shared types and helpers for the counter arbiter: FSM state encoding,
// default counter width and the round-robin selection function.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  localparam int DEFAULT_CNT_W = 8;
  localparam int MAX_REQ       = 16;

  // First set request at or above ptr, wrapping modulo n; caller ensures req != 0.
  function automatic int rr_select(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int   sel;
    int   idx;
    logic found;
    sel   = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (k < n && !found && req[idx[3:0]]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/counter_arbiter_count_unit.sv
// Up-counter shared by all requesters: synchronous clear has priority over enable.
module count_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one up-counter to NUM_REQ timed-interval requesters.
// Optional abort port pair is compiled in with COUNTER_ARBITER_ABORT_EN.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
`ifdef COUNTER_ARBITER_ABORT_EN
  ,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       aborted
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, owner, sel;
  logic [NUM_REQ-1:0] sel_oh;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   len_arr [NUM_REQ];
  logic [MAX_REQ-1:0] req_pad;
  logic               take, clr, en, abort_i, abort_fire, finish;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign len_arr[i] = req_len[i*CNT_W +: CNT_W];
  end

  assign req_pad = MAX_REQ'(req);
  assign sel     = IDX_W'(rr_select(req_pad, int'(ptr), NUM_REQ));
  assign sel_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;

`ifdef COUNTER_ARBITER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign abort_fire = abort_i && (state == LOAD || state == COUNT);
  assign finish     = (state == DONE) || abort_fire;

  always_comb begin
    state_d = state;
    take    = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          take    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        clr = 1'b1;
        if (abort_i)          state_d = IDLE;
        else if (len == '0)   state_d = DONE;
        else                  state_d = COUNT;
      end
      COUNT: begin
        // Counter freezes on len-1 so it reads the last counted value in DONE.
        if (abort_i)                 state_d = IDLE;
        else if (count == len - ONE) state_d = DONE;
        else                         en = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_d;
      if (take) begin
        gnt   <= sel_oh;
        owner <= sel;
      end else if (finish) begin
        gnt <= '0;
        ptr <= (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + IDX_W'(1);
      end
    end
  end

  // Interval length is data: captured once at grant, no reset needed.
  always_ff @(posedge clock) begin
    if (take) len <= len_arr[sel];
  end

`ifdef COUNTER_ARBITER_ABORT_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) aborted <= '0;
    else          aborted <= abort_fire ? gnt : '0;
  end
`endif

  assign done = (state == DONE) ? gnt : '0;
  assign busy = (state != IDLE);

  count_unit #(.CNT_W(CNT_W)) u_count (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (clr),
    .en      (en),
    .value   (count)
  );

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed vectors, corner sequences
// and a randomized run against a transaction-level timing model.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           clear_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [W-1:0]   lens [N];
  logic [N*W-1:0] req_len;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [W-1:0]   count;
`ifdef COUNTER_ARBITER_ABORT_EN
  logic           abort = 1'b0;
  logic [N-1:0]   aborted;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;
  always_comb req_len = {lens[3], lens[2], lens[1], lens[0]};

  counter_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .count   (count)
`ifdef COUNTER_ARBITER_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  typedef struct {
    logic [3:0] rq;
    int         ln;
    logic [3:0] eg;
    int         edone;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_all_len(input int v);
    for (int i = 0; i < N; i++) lens[i] = W'(v);
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    chk("reset gnt", int'(gnt), 0);
    chk("reset done", int'(done), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset count", int'(count), 0);
    @(negedge clock);
    clear_n = 1'b1;
    tick();
  endtask

  // Entered at offset k0 from the IDLE sampling cycle; returns offset of the done pulse.
  task automatic wait_done(input int k0, input int maxk, output int k, output int d);
    k = k0;
    d = 0;
    while (k < maxk) begin
      tick();
      k++;
      if (done != '0) begin
        d = int'(done);
        return;
      end
    end
    k = -1;
  endtask

  // Randomized run checked against the documented timing: a grant sampled in
  // cycle T owns cycles T+1..T+end, counts 0..len-1 from T+2, done at T+end.
  task automatic rand_phase(input int cycles);
    bit   m_active;
    int   m_t, m_end, m_len, m_fin, m_hold, m_owner, m_ptr, d;
    int   eg, ed, eb, ec;
    logic [3:0] rq;
    do_reset();
    m_active = 0; m_hold = 0; m_ptr = 0;
    m_t = 0; m_end = 0; m_len = 0; m_fin = 0; m_owner = 0;
    for (int c = 0; c < cycles; c++) begin
      if (m_active && (c - m_t) > m_end) begin
        m_active = 0;
        m_hold   = m_fin;
      end
      if (!m_active) begin
        eg = 0; ed = 0; eb = 0; ec = m_hold;
      end else begin
        d  = c - m_t;
        eg = 1 << m_owner;
        eb = 1;
        ed = (d == m_end) ? eg : 0;
        if (d == 1)               ec = m_hold;
        else if (d <= m_len + 1)  ec = d - 2;
        else                      ec = m_fin;
      end
      chk("rand gnt", int'(gnt), eg);
      chk("rand done", int'(done), ed);
      chk("rand busy", int'(busy), eb);
      chk("rand count", int'(count), ec);
      rq = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      req = rq;
      for (int i = 0; i < N; i++)
        lens[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      if (!m_active && rq != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_len    = int'(lens[m_owner]);
        m_t      = c;
        m_end    = (m_len == 0) ? 2 : m_len + 2;
        m_fin    = (m_len == 0) ? 0 : m_len - 1;
        m_ptr    = (m_owner + 1) % N;
        m_active = 1;
      end
      tick();
    end
    req = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    int   k, d, g;
    bit   saw_done;
    set_all_len(0);

    // Reset in the middle of an interval
    do_reset();
    req = 4'b0010; lens[1] = 8'd10;
    tick();
    chk("t1 gnt", int'(gnt), 2);
    req = '0;
    k = 0;
    while (count != 8'd5 && k < 50) begin tick(); k++; end
    chk("t1 count reached", int'(count), 5);
    clear_n = 1'b0;
    #1;
    chk("t1 async gnt", int'(gnt), 0);
    chk("t1 async done", int'(done), 0);
    chk("t1 async busy", int'(busy), 0);
    chk("t1 async count", int'(count), 0);
    req = 4'b0011; set_all_len(2);
    @(negedge clock);
    clear_n = 1'b1;
    tick();
    chk("t1 first gnt", int'(gnt), 1);
    req = '0;
    wait_done(1, 50, k, d);
    chk("t1 done at", k, 4);
    tick();

    // Single request, len 3: exact cycle-by-cycle timing
    req = 4'b0001; lens[0] = 8'd3;
    tick();
    chk("t2 gnt", int'(gnt), 1);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2 count", int'(count), i);
      chk("t2 done low", int'(done), 0);
    end
    tick();
    chk("t2 done", int'(done), 1);
    chk("t2 count hold", int'(count), 2);
    tick();
    chk("t2 done pulse", int'(done), 0);
    chk("t2 busy low", int'(busy), 0);

    // Directed vectors from a fresh pointer
    vt[0] = '{4'b0001, 3, 4'b0001, 5};
    vt[1] = '{4'b0011, 0, 4'b0010, 2};
    vt[2] = '{4'b0011, 1, 4'b0001, 3};
    vt[3] = '{4'b1000, 2, 4'b1000, 4};
    vt[4] = '{4'b1111, 4, 4'b0001, 6};
    vt[5] = '{4'b1100, 5, 4'b0100, 7};
    vt[6] = '{4'b0101, 1, 4'b0001, 3};
    do_reset();
    for (int v = 0; v < 7; v++) begin
      req = vt[v].rq;
      set_all_len(vt[v].ln);
      tick();
      chk("vec gnt", int'(gnt), int'(vt[v].eg));
      chk("vec busy", int'(busy), 1);
      req = '0;
      wait_done(1, 400, k, d);
      chk("vec done at", k, vt[v].edone);
      chk("vec done owner", d, int'(vt[v].eg));
      tick();
      chk("vec idle", int'(busy), 0);
    end

    // Fairness with every requester held high
    do_reset();
    set_all_len(2);
    req = 4'b1111;
    for (g = 0; g < 5; g++) begin
      tick();
      chk("t3 gnt order", int'(gnt), 1 << (g % N));
      tick();
      chk("t3 no done c0", int'(done), 0);
      tick();
      chk("t3 no done c1", int'(done), 0);
      tick();
      chk("t3 done", int'(done), 1 << (g % N));
      if (g == 4) req = '0;
      tick();
      chk("t3 done pulse", int'(done), 0);
      chk("t3 gnt cleared", int'(gnt), 0);
    end

    // Maximum length, no wrap
    req = 4'b0100; lens[2] = 8'd255;
    tick();
    chk("t4 gnt", int'(gnt), 4);
    req = '0;
    wait_done(1, 400, k, d);
    chk("t4 done at", k, 257);
    chk("t4 done owner", d, 4);
    chk("t4 final count", int'(count), 254);
    tick();

    // Length and request change during COUNT are ignored
    req = 4'b0100; lens[2] = 8'd6;
    tick();
    tick();
    lens[2] = 8'd50; req = '0;
    wait_done(2, 100, k, d);
    chk("t5 done at", k, 8);
    chk("t5 done owner", d, 4);
    chk("t5 final count", int'(count), 5);
    tick();

`ifdef COUNTER_ARBITER_ABORT_EN
    do_reset();
    req = 4'b1000; lens[3] = 8'd20; lens[0] = 8'd1;
    tick();
    chk("t6 gnt", int'(gnt), 8);
    req = '0;
    k = 0; saw_done = 0;
    while (count != 8'd4 && k < 50) begin
      tick(); k++;
      if (done != '0) saw_done = 1;
    end
    chk("t6 count reached", int'(count), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done != '0) saw_done = 1;
    chk("t6 aborted", int'(aborted), 8);
    chk("t6 busy", int'(busy), 0);
    chk("t6 gnt cleared", int'(gnt), 0);
    chk("t6 no done", int'(saw_done), 0);
    req = 4'b1001;
    tick();
    chk("t6 aborted pulse", int'(aborted), 0);
    chk("t6 next gnt", int'(gnt), 1);
    req = '0;
    wait_done(1, 50, k, d);
    chk("t6 next done", d, 1);
    tick();
`endif

    rand_phase(1500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
